lmsm_sequencer: RTL and testbench

//  ID-stage sequencer for multi-register LM (0110) / SM (0111) instructions. Sits between the IF/ID register and the

---
 rtl/lmsm_pkg.sv | 25 ++
 rtl/lmsm_sequencer_if.sv | 23 ++
 rtl/lmsm_prio_enc.sv | 29 ++
 rtl/lmsm_sequencer.sv | 121 ++++++++++++
 tb/tb_lmsm_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/lmsm_pkg.sv
// Shared constants, state type and rank helper for the LM/SM sequencer.
package lmsm_pkg;

    localparam int unsigned NREG = 8;
    localparam int unsigned OFFW = 6;
    localparam int unsigned RW   = $clog2(NREG);

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {S_IDLE, S_SEQ} state_t;

    // Number of set bits of m strictly below position idx (the transfer's address offset).
    function automatic logic [RW:0] rank_below(input logic [NREG-1:0] m, input logic [RW-1:0] idx);
        logic [RW:0] n;
        n = '0;
        for (int unsigned j = 0; j < NREG; j++) begin
            if (m[j] && (j < 32'(idx))) n = n + (RW+1)'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Instruction path between IF/ID register, sequencer and decoder.
interface lmsm_sequencer_if;

    logic [15:0] ir_in;
    logic        ir_valid;
    logic        hold;
    logic        flush;
    logic [15:0] ir_out;
    logic        ir_out_valid;
    logic        stall_if;
    logic        busy;

    modport master (
        output ir_in, ir_valid, hold, flush,
        input  ir_out, ir_out_valid, stall_if, busy
    );

    modport slave (
        input  ir_in, ir_valid, hold, flush,
        output ir_out, ir_out_valid, stall_if, busy
    );

endinterface

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit encoder; bits in excl_i are chosen only once nothing else is left.
module lmsm_prio_enc
    import lmsm_pkg::*;
(
    input  logic [NREG-1:0] vec_i,
    input  logic [NREG-1:0] excl_i,
    output logic [RW-1:0]   idx_o,
    output logic            valid_o
);

    logic [NREG-1:0] pref;
    logic [NREG-1:0] pick;
    logic            found;

    always_comb begin
        pref    = vec_i & ~excl_i;
        pick    = (|pref) ? pref : vec_i;
        idx_o   = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (pick[i] && !found) begin
                idx_o = RW'(i);
                found = 1'b1;
            end
        end
        valid_o = |vec_i;
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM into one LW/SW micro-op per selected register, stalling fetch meanwhile.
// Optional macro LMSM_BASE_LAST_EN: LM with its base register in the mask loads the base last.
module lmsm_sequencer
    import lmsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    lmsm_sequencer_if.slave  bus
);

    state_t          state_q;
    logic [RW-1:0]   ra_q;
    logic            lm_q;
    logic [NREG-1:0] orig_q;
    logic [NREG-1:0] pend_q;
    logic [15:0]     ir_out_q;
    logic            ir_out_valid_q;

    logic            idle;
    logic [3:0]      in_op;
    logic            in_lmsm;
    logic [NREG-1:0] src_vec;
    logic [NREG-1:0] src_orig;
    logic [RW-1:0]   src_ra;
    logic            src_lm;
    logic [NREG-1:0] excl;
    logic [RW-1:0]   enc_idx;
    logic            enc_valid;
    logic            accept;
    logic [15:0]     uop_d;
    logic [NREG-1:0] pend_d;

    // In IDLE the encoder looks at the incoming instruction so the first micro-op is ready at the accept edge.
    always_comb begin
        idle     = (state_q == S_IDLE);
        in_op    = bus.ir_in[15:12];
        in_lmsm  = (in_op == OP_LM) || (in_op == OP_SM);
        src_vec  = idle ? bus.ir_in[7:0]   : pend_q;
        src_orig = idle ? bus.ir_in[7:0]   : orig_q;
        src_ra   = idle ? bus.ir_in[11:9]  : ra_q;
        src_lm   = idle ? (in_op == OP_LM) : lm_q;
`ifdef LMSM_BASE_LAST_EN
        excl     = src_lm ? (NREG'(1) << src_ra) : '0;
`else
        excl     = '0;
`endif
    end

    lmsm_prio_enc u_enc (
        .vec_i   (src_vec),
        .excl_i  (excl),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        uop_d  = {(src_lm ? OP_LW : OP_SW), enc_idx, src_ra, OFFW'(rank_below(src_orig, enc_idx))};
        pend_d = src_vec & ~(NREG'(1) << enc_idx);
        accept = idle && bus.ir_valid && in_lmsm && enc_valid && !bus.hold && !bus.flush;
    end

    // Outputs are pass-through in IDLE, registered in SEQ, and forced to zero while reset is held.
    always_comb begin
        bus.ir_out       = '0;
        bus.ir_out_valid = 1'b0;
        bus.stall_if     = 1'b0;
        bus.busy         = 1'b0;
        if (!rst) begin
            if (idle) begin
                bus.ir_out       = bus.ir_in;
                bus.ir_out_valid = bus.ir_valid && !in_lmsm;
                bus.stall_if     = bus.hold || accept;
            end else begin
                bus.ir_out       = ir_out_q;
                bus.ir_out_valid = ir_out_valid_q;
                bus.stall_if     = !bus.flush && (bus.hold || enc_valid);
                bus.busy         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ra_q           <= '0;
            lm_q           <= 1'b0;
            orig_q         <= '0;
            pend_q         <= '0;
            ir_out_q       <= '0;
            ir_out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state_q        <= S_IDLE;
            pend_q         <= '0;
            ir_out_valid_q <= 1'b0;
        end else if (!bus.hold) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        ra_q           <= bus.ir_in[11:9];
                        lm_q           <= (in_op == OP_LM);
                        orig_q         <= bus.ir_in[7:0];
                        pend_q         <= pend_d;
                        ir_out_q       <= uop_d;
                        ir_out_valid_q <= 1'b1;
                        state_q        <= S_SEQ;
                    end
                end
                S_SEQ: begin
                    if (enc_valid) begin
                        ir_out_q <= uop_d;
                        pend_q   <= pend_d;
                    end else begin
                        ir_out_valid_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer; expected micro-op lists come from a list-based LM/SM expansion model.
module tb_lmsm_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lmsm_sequencer_if bus_if ();

    lmsm_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef logic [15:0] q16_t[$];
    typedef struct {
        logic [15:0] out;
        logic        vld;
        logic        stall;
        logic        busy;
        logic        chk;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference expansion: registers in ascending order, offset = position in that ascending list.
    task automatic expand(input logic [15:0] ir, output q16_t q);
        logic [2:0] ra;
        logic [7:0] mask;
        logic       lm;
        int         rank [8];
        int         order[$];
        int         cnt;
        q    = {};
        lm   = (ir[15:12] == 4'b0110);
        ra   = ir[11:9];
        mask = ir[7:0];
        cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            rank[i] = cnt;
            if (mask[i]) begin
                order.push_back(i);
                cnt++;
            end
        end
`ifdef LMSM_BASE_LAST_EN
        if (lm && mask[ra]) begin
            foreach (order[j]) if (order[j] == int'(ra)) begin
                order.delete(j);
                break;
            end
            order.push_back(int'(ra));
        end
`endif
        foreach (order[j])
            q.push_back({(lm ? 4'b0100 : 4'b0101), 3'(order[j]), ra, 6'(rank[order[j]])});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".valid"}, 16'(bus_if.ir_out_valid), 16'(e.vld));
            check({e.tag, ".stall"}, 16'(bus_if.stall_if),     16'(e.stall));
            check({e.tag, ".busy"},  16'(bus_if.busy),         16'(e.busy));
            if (e.chk) check({e.tag, ".ir_out"}, bus_if.ir_out, e.out);
        end
    end

    task automatic step(input string tag, input logic [15:0] ir, input logic v, h, f, r,
                        input logic [15:0] eout, input logic evld, estall, ebusy, echk);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus_if.ir_in    = ir;
        bus_if.ir_valid = v;
        bus_if.hold     = h;
        bus_if.flush    = f;
        e.out = eout; e.vld = evld; e.stall = estall; e.busy = ebusy; e.chk = echk; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic pass(input string tag, input logic [15:0] ir);
        step(tag, ir, 1'b1, 1'b0, 1'b0, 1'b0, ir, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    // Bubble then one micro-op per cycle; optional 2-cycle hold or a flush at micro-op index.
    task automatic run_seq(input string tag, input logic [15:0] ir, input int hold_at, input int flush_at);
        q16_t u;
        expand(ir, u);
        step({tag, ".bubble"}, ir, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        foreach (u[j]) begin
            if (j == hold_at) begin
                repeat (2) step({tag, ".hold"}, ir, 1'b1, 1'b1, 1'b0, 1'b0, u[j], 1'b1, 1'b1, 1'b1, 1'b1);
            end
            if (j == flush_at) begin
                step({tag, ".flush"}, ir, 1'b1, 1'b0, 1'b1, 1'b0, u[j], 1'b1, 1'b0, 1'b1, 1'b1);
                return;
            end
            step({tag, ".uop"}, ir, 1'b1, 1'b0, 1'b0, 1'b0, u[j], 1'b1, (j != u.size() - 1), 1'b1, 1'b1);
        end
    endtask

    initial begin
        q16_t u;
        bus_if.ir_in    = 16'h0;
        bus_if.ir_valid = 1'b0;
        bus_if.hold     = 1'b0;
        bus_if.flush    = 1'b0;

        // Model pinned against hand-computed encodings.
        expand(16'h640B, u);
        check("pin.lm_r2.n", 16'(u.size()), 16'd3);
        if (u.size() == 3) begin
            check("pin.lm_r2.0", u[0], 16'h4080);
            check("pin.lm_r2.1", u[1], 16'h4281);
            check("pin.lm_r2.2", u[2], 16'h4682);
        end
        expand(16'h7A80, u);
        check("pin.sm_r5.0", u[0], 16'h5F40);
        expand(16'h6207, u);
`ifdef LMSM_BASE_LAST_EN
        check("pin.lm_r1.0", u[0], 16'h4040);
        check("pin.lm_r1.1", u[1], 16'h4442);
        check("pin.lm_r1.2", u[2], 16'h4241);
`else
        check("pin.lm_r1.0", u[0], 16'h4040);
        check("pin.lm_r1.1", u[1], 16'h4241);
        check("pin.lm_r1.2", u[2], 16'h4442);
`endif

        step("reset", 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("reset2", 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        pass("add", 16'h1234);
        step("novalid", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);

        run_seq("lm_r2", 16'h640B, -1, -1);
        pass("add_after_lm_r2", 16'h1234);
        run_seq("lm_r1", 16'h6207, -1, -1);
        pass("add_after_lm_r1", 16'h2345);
        run_seq("sm_r5", 16'h7A80, -1, -1);
        pass("add_after_sm_r5", 16'h1234);

        step("lm_zero", 16'h6000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        pass("add_after_zero", 16'h1111);

        step("idle_hold", 16'h6C0E, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_seq("lm_r6", 16'h6C0E, 1, -1);
        pass("add_after_hold", 16'h1234);

        run_seq("sm_r3", 16'h76A5, -1, 1);
        pass("add_after_flush", 16'h3456);
        pass("add_after_flush2", 16'h4567);

        expand(16'h60F0, u);
        step("rst_seq.bubble", 16'h60F0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("rst_seq.uop0", 16'h60F0, 1'b1, 1'b0, 1'b0, 1'b0, u[0], 1'b1, 1'b1, 1'b1, 1'b1);
        step("rst_seq.rst", 16'h60F0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rst_seq.after", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        pass("add_after_rst", 16'h1234);

        repeat (3) @(posedge clk);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
